m_ext_scheduler: RTL and testbench
==================================

// Module: m_ext_scheduler
// PURPOSE
//  Sequencer between the EX stage and the iterative M-extension units (multiplier, divider).
//  Latches one M-op, dispatches it to the correct unit, holds enable/operands/funct3 stable
//  until the unit responds, then returns one 32-bit result while stalling the pipeline.
//  Sits in EX next to the ALU; owns all multiplier/divider enables.
// PARAMETERS
//  WIDTH     32  operand/result width (only 32 supported)
// PORTS
//  clk         in   1   single clock
//  rst_n       in   1   synchronous reset, active-low
//  req_valid   in   1   EX holds an M-ext op (held until rsp_valid)
//  req_funct3  in   3   M-ext funct3 (000-011 mul class, 100-111 div class)
//  req_a       in   32  rs1 value
//  req_b       in   32  rs2 value
//  flush       in   1   kill in-flight op (branch mispredict / trap)
//  stall_o     out  1   freeze pipeline
//  rsp_valid   out  1   1-cycle result strobe
//  rsp_data    out  32  result
//  mul_enable  out  1   multiplier run; mul_funct3/mul_a/mul_b out 3/32/32 (held stable)
//  mul_resp    in   1   multiplier done; mul_f in 32 result
//  div_enable  out  1   divider run; div_funct3/div_a/div_b out 3/32/32 (held stable)
//  div_resp    in   1   divider done; div_f in 32 result
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; all outputs 0; op regs 0; cache tag invalid.
//  States: IDLE, MUL_BUSY, DIV_BUSY, DONE.
//  IDLE: if req_valid & ~flush -> latch funct3/a/b; funct3[2]=0 -> MUL_BUSY, else DIV_BUSY.
//   stall_o = req_valid & ~flush (combinational, so the first cycle stalls).
//  *_BUSY: enable of selected unit = 1, other = 0; unit operands/funct3 driven from latched regs.
//   Operands never change mid-op. stall_o=1.
//   resp=1 -> capture unit result into res_q; -> DONE.
//   flush=1 (takes priority over resp) -> IDLE, no rsp_valid, result discarded.
//  DONE: rsp_valid=1, rsp_data=res_q, stall_o=0, both enables 0 -> IDLE.
//  Enables are always low for >=1 cycle between ops (DONE/IDLE); required so units clear internal valid.
//  Latency (IDLE accept to rsp_valid) = unit cycles + 2. Only one op is ever in flight.
//  flush in DONE: rsp_valid still 1; pipeline discards it.
//  flush in IDLE: request ignored.
//  Unit result/special cases (div by 0, overflow) are passed through unmodified.
//  rsp_data = 0 whenever rsp_valid = 0.
// CONFIGURATION
//  MEXT_RESULT_CACHE_EN defined:
//   One-entry cache {valid, funct3, a, b, result}, written in DONE (never for flushed ops).
//   IDLE accept with tag match -> DONE directly (res_q = cached); no unit enabled; latency 2.
//   Invalidated only by reset.
//  MEXT_RESULT_CACHE_EN undefined: no cache storage; every op dispatched to its unit.
// STRUCTURE
//  rv32i_types gains m_funct3_t enum (mul..remu) and mext_state_t enum (four states above).
//  Optional sub-module m_ext_result_cache (tag compare + storage), instantiated only under the macro.
//  FSM, operand regs and result mux stay in this module.
// TESTING
//  1. mul(000) a=7 b=0xFFFFFFFD -> rsp_data=0xFFFFFFEB; 1 rsp_valid pulse; stall_o low only in DONE;
//     mul_enable low the cycle after mul_resp.
//  2. mulhu(011) a=b=0xFFFFFFFF -> 0xFFFFFFFE; mulh(001) a=0x80000000 b=2 -> 0xFFFFFFFF.
//  3. divu(101) 100/7 -> 14, then remu(111) 100/7 -> 2, back-to-back;
//     >=1 enable-low cycle between ops; div_enable only.
//  4. flush on 3rd MUL_BUSY cycle -> next cycle IDLE, mul_enable=0, stall_o=0, no rsp_valid;
//     following mul 3*4 -> 12.
//  5. rst_n=0 one cycle mid DIV_BUSY -> all outputs 0 next cycle, state IDLE;
//     new op after reset completes correctly.
//  6. Macro on: mulh 0x12345678*0x9ABCDEF0 twice -> second rsp in 2 cycles with same data,
//     mul_enable never asserted. Macro off: full latency, same data.

Source files
------------

// File: rtl/m_ext_scheduler_pkg.sv
// Shared types for the M-extension scheduler: operand width, funct3 encodings,
// FSM state encoding and a small decode helper.
package m_ext_scheduler_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } m_funct3_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DIV_BUSY = 2'd2,
    ST_DONE     = 2'd3
  } mext_state_t;

  // funct3[2] separates the divide class from the multiply class.
  function automatic logic is_div_op(input m_funct3_t f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/m_ext_scheduler_if.sv
// Bundle of the EX-side request/response signals and the multiplier/divider
// side-band. Handshake: EX holds req_valid (and operands) until it sees the
// one-cycle rsp_valid strobe; a unit holds *_enable-driven work until it
// pulses *_resp, and the scheduler drops *_enable for at least one cycle
// before the next op so the unit can clear its internal state.
// master = scheduler view, slave = EX stage plus the two units.
interface m_ext_scheduler_if;
  logic                                  req_valid;
  logic [2:0]                            req_funct3;
  logic [m_ext_scheduler_pkg::WIDTH-1:0] req_a;
  logic [m_ext_scheduler_pkg::WIDTH-1:0] req_b;
  logic                                  flush;
  logic                                  stall_o;
  logic                                  rsp_valid;
  logic [m_ext_scheduler_pkg::WIDTH-1:0] rsp_data;
  logic                                  mul_enable;
  logic [2:0]                            mul_funct3;
  logic [m_ext_scheduler_pkg::WIDTH-1:0] mul_a;
  logic [m_ext_scheduler_pkg::WIDTH-1:0] mul_b;
  logic                                  mul_resp;
  logic [m_ext_scheduler_pkg::WIDTH-1:0] mul_f;
  logic                                  div_enable;
  logic [2:0]                            div_funct3;
  logic [m_ext_scheduler_pkg::WIDTH-1:0] div_a;
  logic [m_ext_scheduler_pkg::WIDTH-1:0] div_b;
  logic                                  div_resp;
  logic [m_ext_scheduler_pkg::WIDTH-1:0] div_f;

  modport master (
    input  req_valid, req_funct3, req_a, req_b, flush,
    input  mul_resp, mul_f, div_resp, div_f,
    output stall_o, rsp_valid, rsp_data,
    output mul_enable, mul_funct3, mul_a, mul_b,
    output div_enable, div_funct3, div_a, div_b
  );

  modport slave (
    output req_valid, req_funct3, req_a, req_b, flush,
    output mul_resp, mul_f, div_resp, div_f,
    input  stall_o, rsp_valid, rsp_data,
    input  mul_enable, mul_funct3, mul_a, mul_b,
    input  div_enable, div_funct3, div_a, div_b
  );
endinterface

// File: rtl/m_ext_scheduler_result_cache.sv
// One-entry result cache {valid, funct3, a, b, result} for the M-extension
// scheduler. Only built when MEXT_RESULT_CACHE_EN is defined. The entry is
// invalidated only by reset; a write simply replaces it.
module m_ext_result_cache
  import m_ext_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  m_funct3_t        wr_funct3_i,
  input  logic [WIDTH-1:0] wr_a_i,
  input  logic [WIDTH-1:0] wr_b_i,
  input  logic [WIDTH-1:0] wr_res_i,
  input  m_funct3_t        lk_funct3_i,
  input  logic [WIDTH-1:0] lk_a_i,
  input  logic [WIDTH-1:0] lk_b_i,
  output logic             hit_o,
  output logic [WIDTH-1:0] hit_data_o
);

  logic             valid_q;
  m_funct3_t        funct3_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;

  // Entry storage: cleared by reset, overwritten by each completed op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      funct3_q <= M_MUL;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
    end else if (wr_en_i) begin
      valid_q  <= 1'b1;
      funct3_q <= wr_funct3_i;
      a_q      <= wr_a_i;
      b_q      <= wr_b_i;
      res_q    <= wr_res_i;
    end
  end

  assign hit_o      = valid_q && (funct3_q == lk_funct3_i) && (a_q == lk_a_i) && (b_q == lk_b_i);
  assign hit_data_o = res_q;

endmodule

// File: rtl/m_ext_scheduler.sv
// Sequencer between EX and the iterative multiplier/divider. Latches one
// M-op, runs it on the selected unit with operands frozen, and returns one
// result strobe while stalling the pipeline.
// Optional feature: MEXT_RESULT_CACHE_EN adds a one-entry result cache so a
// repeated op completes without enabling a unit.
module m_ext_scheduler
  import m_ext_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  m_ext_scheduler_if.master   bus,
  output mext_state_t         state_o
);

  mext_state_t      state_q,  state_d;
  m_funct3_t        funct3_q, funct3_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             stall;
  logic             accept;

  assign accept = bus.req_valid && !bus.flush;

`ifdef MEXT_RESULT_CACHE_EN
  logic             cache_hit;
  logic [WIDTH-1:0] cache_data;

  // Written on every DONE; flushed ops never reach DONE so they are never cached.
  m_ext_result_cache u_cache (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (state_q == ST_DONE),
    .wr_funct3_i (funct3_q),
    .wr_a_i      (a_q),
    .wr_b_i      (b_q),
    .wr_res_i    (res_q),
    .lk_funct3_i (m_funct3_t'(bus.req_funct3)),
    .lk_a_i      (bus.req_a),
    .lk_b_i      (bus.req_b),
    .hit_o       (cache_hit),
    .hit_data_o  (cache_data)
  );
`endif

  // State, latched operands and captured result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      funct3_q <= M_MUL;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
    end
  end

  // Next-state, operand latch and stall; flush beats resp in the busy states.
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    stall    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          stall    = 1'b1;
          funct3_d = m_funct3_t'(bus.req_funct3);
          a_d      = bus.req_a;
          b_d      = bus.req_b;
`ifdef MEXT_RESULT_CACHE_EN
          if (cache_hit) begin
            res_d   = cache_data;
            state_d = ST_DONE;
          end else
`endif
          if (is_div_op(m_funct3_t'(bus.req_funct3))) state_d = ST_DIV_BUSY;
          else                                         state_d = ST_MUL_BUSY;
        end
      end
      ST_MUL_BUSY: begin
        stall = 1'b1;
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (bus.mul_resp) begin
          res_d   = bus.mul_f;
          state_d = ST_DONE;
        end
      end
      ST_DIV_BUSY: begin
        stall = 1'b1;
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (bus.div_resp) begin
          res_d   = bus.div_f;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.stall_o    = stall;
  assign bus.rsp_valid  = (state_q == ST_DONE);
  assign bus.rsp_data   = (state_q == ST_DONE) ? res_q : '0;
  assign bus.mul_enable = (state_q == ST_MUL_BUSY);
  assign bus.mul_funct3 = funct3_q;
  assign bus.mul_a      = a_q;
  assign bus.mul_b      = b_q;
  assign bus.div_enable = (state_q == ST_DIV_BUSY);
  assign bus.div_funct3 = funct3_q;
  assign bus.div_a      = a_q;
  assign bus.div_b      = b_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_m_ext_scheduler.sv
// Bench for m_ext_scheduler with behavioural multiplier/divider units.
// Build with or without MEXT_RESULT_CACHE_EN; the cache scenario adapts.
module tb_m_ext_scheduler;
  import m_ext_scheduler_pkg::*;

  localparam int W       = 32;
  localparam int MUL_LAT = 3;  // enable-high cycles before mul_resp
  localparam int DIV_LAT = 6;  // enable-high cycles before div_resp

  logic        clk;
  logic        rst_n;
  mext_state_t state;

  m_ext_scheduler_if bus();

  m_ext_scheduler dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // RISC-V M-extension reference results (including div-by-zero / overflow).
  function automatic logic [W-1:0] m_ref(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    case (f3)
      3'b000: begin p = a * b; return p[31:0]; end
      3'b001: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'b010: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // ---------------- behavioural units ----------------
  int mul_cnt;
  int div_cnt;

  always @(posedge clk) begin
    if (!rst_n || !bus.mul_enable) begin
      mul_cnt      <= 0;
      bus.mul_resp <= 1'b0;
      if (!rst_n) bus.mul_f <= '0;
    end else if (bus.mul_resp) begin
      bus.mul_resp <= 1'b0;
    end else if (mul_cnt == MUL_LAT - 1) begin
      bus.mul_resp <= 1'b1;
      bus.mul_f    <= m_ref(bus.mul_funct3, bus.mul_a, bus.mul_b);
    end else begin
      mul_cnt <= mul_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst_n || !bus.div_enable) begin
      div_cnt      <= 0;
      bus.div_resp <= 1'b0;
      if (!rst_n) bus.div_f <= '0;
    end else if (bus.div_resp) begin
      bus.div_resp <= 1'b0;
    end else if (div_cnt == DIV_LAT - 1) begin
      bus.div_resp <= 1'b1;
      bus.div_f    <= m_ref(bus.div_funct3, bus.div_a, bus.div_b);
    end else begin
      div_cnt <= div_cnt + 1;
    end
  end

  // ---------------- monitor ----------------
  int           mul_en_cycles = 0;
  int           div_en_cycles = 0;
  logic         mul_en_prev   = 1'b0;
  logic         div_en_prev   = 1'b0;
  logic         mul_resp_prev = 1'b0;
  logic [2:0]   hold_mf3, hold_df3;
  logic [W-1:0] hold_ma, hold_mb, hold_da, hold_db;

  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) check_eq("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      else                   check_eq("rsp_data", bus.rsp_data, exp_q.pop_front());
    end else begin
      check_eq("rsp_data_idle_zero", bus.rsp_data, '0);
    end
    check_eq("enable_exclusive", 32'(bus.mul_enable & bus.div_enable), 32'd0);
    if (mul_resp_prev) check_eq("mul_en_after_resp", 32'(bus.mul_enable), 32'd0);
    if (bus.mul_enable) begin
      mul_en_cycles++;
      if (mul_en_prev) begin
        check_eq("mul_funct3_stable", 32'(bus.mul_funct3), 32'(hold_mf3));
        check_eq("mul_a_stable", bus.mul_a, hold_ma);
        check_eq("mul_b_stable", bus.mul_b, hold_mb);
      end else begin
        hold_mf3 = bus.mul_funct3; hold_ma = bus.mul_a; hold_mb = bus.mul_b;
      end
    end
    if (bus.div_enable) begin
      div_en_cycles++;
      if (div_en_prev) begin
        check_eq("div_funct3_stable", 32'(bus.div_funct3), 32'(hold_df3));
        check_eq("div_a_stable", bus.div_a, hold_da);
        check_eq("div_b_stable", bus.div_b, hold_db);
      end else begin
        hold_df3 = bus.div_funct3; hold_da = bus.div_a; hold_db = bus.div_b;
      end
    end
    mul_en_prev   = bus.mul_enable;
    div_en_prev   = bus.div_enable;
    mul_resp_prev = bus.mul_resp;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge. Presents one op, waits for the result strobe and
  // checks stall, state and (if exp_lat > 0) latency counted inclusively
  // from the accept cycle to the rsp_valid cycle.
  task automatic run_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int exp_lat);
    int n;
    bit got;
    exp_q.push_back(exp);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_a      = a;
    bus.req_b      = b;
    #1;
    check_eq("stall_first_cycle", 32'(bus.stall_o), 32'd1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid) got = 1'b1;
      else               check_eq("stall_busy", 32'(bus.stall_o), 32'd1);
    end
    if (!got) begin
      check_eq("rsp_timeout", 32'(got), 32'd1);
      void'(exp_q.pop_back());
    end else begin
      check_eq("stall_done", 32'(bus.stall_o), 32'd0);
      check_eq("state_done", 32'(state), 32'(ST_DONE));
      check_eq("en_low_in_done", 32'(bus.mul_enable | bus.div_enable), 32'd0);
      if (exp_lat > 0) check_eq("latency", 32'(n + 1), 32'(exp_lat));
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq("single_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int          m0, d0;
  logic [W-1:0] ra, rb;
  logic [2:0]   rf;

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.flush      = 1'b0;
    idle_cycles(3);

    // Reset state
    check_eq("rst_state", 32'(state), 32'(ST_IDLE));
    check_eq("rst_stall", 32'(bus.stall_o), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_mul_en", 32'(bus.mul_enable), 32'd0);
    check_eq("rst_div_en", 32'(bus.div_enable), 32'd0);
    check_eq("rst_mul_a", bus.mul_a, '0);
    check_eq("rst_div_b", bus.div_b, '0);
    rst_n = 1'b1;
    idle_cycles(2);

    // 1. mul 7 * -3; unit busy MUL_LAT cycles plus the resp cycle, +2
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT + 3);

    // 2. high-half multiplies
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT + 3);
    run_op(3'b001, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 0);

    // 3. divu then remu back-to-back, divider only
    m0 = mul_en_cycles;
    d0 = div_en_cycles;
    run_op(3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT + 3);
    run_op(3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT + 3);
    check_eq("div_only_mul_idle", 32'(mul_en_cycles - m0), 32'd0);
    check_eq("div_only_div_ran", 32'(div_en_cycles - d0 > 0), 32'd1);

    // Special cases pass straight through
    run_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);

    // 4. flush on the third MUL_BUSY cycle, then flush held in IDLE
    bus.req_valid  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_a      = 32'd5;
    bus.req_b      = 32'd6;
    idle_cycles(3);
    check_eq("pre_flush_state", 32'(state), 32'(ST_MUL_BUSY));
    bus.flush = 1'b1;
    @(negedge clk);
    check_eq("flush_state", 32'(state), 32'(ST_IDLE));
    check_eq("flush_mul_en", 32'(bus.mul_enable), 32'd0);
    check_eq("flush_stall", 32'(bus.stall_o), 32'd0);
    check_eq("flush_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("flush_idle_ignored", 32'(state), 32'(ST_IDLE));
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    idle_cycles(2);
    run_op(3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT + 3);

    // 5. reset in the middle of DIV_BUSY
    bus.req_valid  = 1'b1;
    bus.req_funct3 = 3'b101;
    bus.req_a      = 32'd1000;
    bus.req_b      = 32'd3;
    idle_cycles(3);
    check_eq("pre_rst_state", 32'(state), 32'(ST_DIV_BUSY));
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq("midrst_state", 32'(state), 32'(ST_IDLE));
    check_eq("midrst_div_en", 32'(bus.div_enable), 32'd0);
    check_eq("midrst_stall", 32'(bus.stall_o), 32'd0);
    check_eq("midrst_div_a", bus.div_a, '0);
    check_eq("midrst_div_b", bus.div_b, '0);
    check_eq("midrst_div_f3", 32'(bus.div_funct3), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);
    run_op(3'b101, 32'd1000, 32'd3, 32'd333, DIV_LAT + 3);

    // 6. repeated mulh: cache hit when built with MEXT_RESULT_CACHE_EN
    run_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, m_ref(3'b001, 32'h1234_5678, 32'h9ABC_DEF0), MUL_LAT + 3);
    m0 = mul_en_cycles;
`ifdef MEXT_RESULT_CACHE_EN
    run_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, m_ref(3'b001, 32'h1234_5678, 32'h9ABC_DEF0), 2);
    check_eq("cache_no_mul_en", 32'(mul_en_cycles - m0), 32'd0);
`else
    run_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, m_ref(3'b001, 32'h1234_5678, 32'h9ABC_DEF0), MUL_LAT + 3);
    check_eq("nocache_mul_ran", 32'(mul_en_cycles - m0 > 0), 32'd1);
`endif

    // Random ops across both classes
    for (int i = 0; i < 12; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op(rf, ra, rb, m_ref(rf, ra, rb), 0);
    end

    idle_cycles(3);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
